// File: rtl/game_controller_if.sv
// Command/status bundle between the memory-game controller and its datapath.
// The enter key travels with the status flags because the controller is its only consumer.
interface game_controller_if;
    // user key (active-low, asynchronous to CLOCK_50)
    logic       enter_n;
    // datapath status flags
    logic       end_FPGA;
    logic       end_User;
    logic       end_time;
    logic       win;
    logic       match;
    // datapath commands
    logic       R1;
    logic       R2;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       SEL;
    // debug view of the FSM state
    logic [2:0] state;

    // controller side
    modport master (
        input  enter_n, end_FPGA, end_User, end_time, win, match,
        output R1, R2, E1, E2, E3, E4, SEL, state
    );

    // datapath / environment side
    modport slave (
        output enter_n, end_FPGA, end_User, end_time, win, match,
        input  R1, R2, E1, E2, E3, E4, SEL, state
    );
endinterface

// File: rtl/game_controller.sv
// Memory-game control FSM. Sequences the datapath: clear, setup, FPGA playback
// paced by a step counter, user entry, compare, level advance and a result screen
// that must be shown for a minimum time before enter restarts the game.
// Every command output is a flop; the Moore decodes are taken from the next state
// so they line up exactly with the state register.
module game_controller #(
    parameter int STEP_CYCLES = 25000000,
    parameter int RESULT_HOLD = 50000000,
    // shared pacer/hold counter width; must also hold STEP_CYCLES-1
    parameter int CNT_W       = $clog2(RESULT_HOLD + 1)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    game_controller_if.master gc
);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PREP      = 3'd2,
        ST_PLAY_FPGA = 3'd3,
        ST_PLAY_USER = 3'd4,
        ST_CHECK     = 3'd5,
        ST_NEXT      = 3'd6,
        ST_RESULT    = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(RESULT_HOLD);

    // enter key conditioning
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic enter_p_s;

    // FSM and shared counter
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // pulse requests decided alongside the next state
    logic e2_d;
    logic e3_d;

    // registered command outputs
    logic r1_q;
    logic r2_q;
    logic e1_q;
    logic e2_q;
    logic e3_q;
    logic e4_q;
    logic sel_q;

    // Two-flop synchronizer plus one history flop for the press detector; all idle at 1 (released).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= gc.enter_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A press is the 1->0 transition of the synchronized key; a held key yields a single pulse.
    assign enter_p_s = prev_q & ~sync2_q;

    // State and counter registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and pulse-request logic. The counter defaults to zero, so any
    // state that does not own it leaves it cleared for the next owner (PLAY_FPGA or RESULT).
    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        e2_d    = 1'b0;
        e3_d    = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (enter_p_s) begin
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_PREP: begin
                state_d = ST_PLAY_FPGA;
            end
            ST_PLAY_FPGA: begin
                if (gc.end_FPGA) begin
                    // playback done: leave without stepping the sequence again
                    state_d = ST_PLAY_USER;
                end else if (cnt_q == STEP_LAST) begin
                    e2_d  = 1'b1;
                    cnt_d = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PLAY_USER: begin
                if (gc.end_time) begin
                    // timeout wins over everything, including a pending entry
                    state_d = ST_RESULT;
                end else if (gc.end_User) begin
                    state_d = ST_CHECK;
                end else if (enter_p_s) begin
                    e3_d = 1'b1;
                end else begin
                    state_d = ST_PLAY_USER;
                end
            end
            ST_CHECK: begin
                if (gc.match && !gc.win) begin
                    state_d = ST_NEXT;
                end else begin
                    // either the last level was won or the entry was wrong
                    state_d = ST_RESULT;
                end
            end
            ST_NEXT: begin
                state_d = ST_PREP;
            end
            ST_RESULT: begin
                if (cnt_q == HOLD_MAX) begin
                    if (enter_p_s) begin
                        state_d = ST_INIT;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    // presses before the hold time has elapsed are simply dropped
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Command outputs registered from the next state so they are glitch-free and track state_q.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r1_q  <= 1'b1;
            r2_q  <= 1'b1;
            e1_q  <= 1'b0;
            e2_q  <= 1'b0;
            e3_q  <= 1'b0;
            e4_q  <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            r1_q  <= (state_d == ST_INIT);
            r2_q  <= (state_d == ST_INIT) || (state_d == ST_PREP);
            e1_q  <= (state_d == ST_SETUP);
            e2_q  <= e2_d;
            e3_q  <= e3_d;
            e4_q  <= (state_d == ST_NEXT);
            sel_q <= (state_d == ST_RESULT);
        end
    end

    assign gc.R1    = r1_q;
    assign gc.R2    = r2_q;
    assign gc.E1    = e1_q;
    assign gc.E2    = e2_q;
    assign gc.E3    = e3_q;
    assign gc.E4    = e4_q;
    assign gc.SEL   = sel_q;
    assign gc.state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller with short pacing (STEP_CYCLES=4, RESULT_HOLD=8).
// A directed walk through the game flow is followed by randomized key presses,
// flags and mid-game resets; every cycle the DUT is compared with a reference
// model that tracks the game state and the time spent in it.
module tb_game_controller;

    localparam int STEP = 4;
    localparam int HOLD = 8;

    logic clk;
    logic rst;

    game_controller_if gc_bus ();

    game_controller #(
        .STEP_CYCLES (STEP),
        .RESULT_HOLD (HOLD)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .gc       (gc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int   m_state;      // 0..7 game state
    int   m_time;       // cycles spent in the current state
    logic m_e2;
    logic m_e3;
    logic en_hist[$];   // enter_n as sampled on the last three clock edges

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_time  = 0;
        m_e2    = 1'b0;
        m_e3    = 1'b0;
        en_hist = '{1'b1, 1'b1, 1'b1};
    endtask

    // One clock edge of the game rules. A key press is recognised on the second edge
    // after the key is first sampled low, after having been sampled high before that.
    task automatic model_step();
        logic press;
        int   nxt;
        press = en_hist[$-2] && !en_hist[$-1];
        en_hist.push_back(gc_bus.enter_n);
        void'(en_hist.pop_front());
        nxt  = m_state;
        m_e2 = 1'b0;
        m_e3 = 1'b0;
        case (m_state)
            0: nxt = 1;
            1: if (press) nxt = 2;
            2: nxt = 3;
            3: begin
                if (gc_bus.end_FPGA) nxt = 4;
                else if ((m_time % STEP) == STEP - 1) m_e2 = 1'b1;
            end
            4: begin
                if (gc_bus.end_time) nxt = 7;
                else if (gc_bus.end_User) nxt = 5;
                else if (press) m_e3 = 1'b1;
            end
            5: nxt = (gc_bus.match && !gc_bus.win) ? 6 : 7;
            6: nxt = 2;
            7: if (m_time >= HOLD && press) nxt = 0;
            default: nxt = 0;
        endcase
        m_time  = (nxt == m_state) ? m_time + 1 : 0;
        m_state = nxt;
    endtask

    task automatic check_outputs(input string tag);
        logic [6:0] exp_cmd;
        logic [6:0] obs_cmd;
        exp_cmd = {(m_state == 0), (m_state == 0 || m_state == 2), (m_state == 1),
                   m_e2, m_e3, (m_state == 6), (m_state == 7)};
        obs_cmd = {gc_bus.R1, gc_bus.R2, gc_bus.E1, gc_bus.E2, gc_bus.E3, gc_bus.E4, gc_bus.SEL};
        check_value({tag, ".state"}, {13'd0, gc_bus.state}, 16'(m_state));
        check_value({tag, ".cmd"}, {9'd0, obs_cmd}, {9'd0, exp_cmd});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic clear_flags();
        gc_bus.end_FPGA = 1'b0;
        gc_bus.end_User = 1'b0;
        gc_bus.end_time = 1'b0;
        gc_bus.win      = 1'b0;
        gc_bus.match    = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle, held over one edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".hold"});
        rst = 1'b0;
    endtask

    task automatic press_key(input string tag, input int low_cycles);
        gc_bus.enter_n = 1'b0;
        ticks(tag, low_cycles);
        gc_bus.enter_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        gc_bus.enter_n = 1'b1;
        clear_flags();
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        rst = 1'b0;

        // idle: INIT for one cycle then SETUP indefinitely
        ticks("idle", 6);

        // long press in SETUP -> single PREP, playback with paced steps
        press_key("setup_press", 5);
        ticks("playback", 10);
        for (int i = 0; i < 40 && !(m_state == 3 && (m_time % STEP) == STEP - 1); i++)
            tick("to_pulse");
        gc_bus.end_FPGA = 1'b1;
        tick("end_fpga_on_pulse");
        gc_bus.end_FPGA = 1'b0;

        // three entries, then a correct non-final round
        for (int k = 0; k < 3; k++) begin
            press_key("user_press", 2);
            ticks("user_gap", 3);
        end
        gc_bus.end_User = 1'b1;
        gc_bus.match    = 1'b1;
        tick("round_ok");
        clear_flags();
        ticks("next_round", 6);

        // timeout beats end_User
        gc_bus.end_FPGA = 1'b1;
        tick("fpga_done");
        gc_bus.end_FPGA = 1'b0;
        gc_bus.end_time = 1'b1;
        gc_bus.end_User = 1'b1;
        tick("timeout");
        clear_flags();

        // early press ignored, late press restarts
        tick("result");
        press_key("early_press", 2);
        ticks("result_wait", 8);
        press_key("late_press", 3);
        ticks("restart", 4);

        // wrong entry -> RESULT through CHECK
        press_key("setup_press2", 2);
        ticks("prep2", 4);
        gc_bus.end_FPGA = 1'b1;
        tick("fpga_done2");
        gc_bus.end_FPGA = 1'b0;
        gc_bus.end_User = 1'b1;
        tick("wrong_entry");
        clear_flags();
        ticks("result2", 12);
        press_key("result_exit", 2);
        ticks("restart2", 4);

        // reset between playback steps, then the pacer starts over
        press_key("setup_press3", 2);
        ticks("prep3", 6);
        do_reset("rst_play");
        ticks("after_rst", 4);
        press_key("setup_press4", 2);
        ticks("play4", 12);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) gc_bus.enter_n = ~gc_bus.enter_n;
            gc_bus.end_FPGA = ($urandom_range(0, 7) == 0);
            gc_bus.end_User = ($urandom_range(0, 7) == 0);
            gc_bus.end_time = ($urandom_range(0, 15) == 0);
            gc_bus.match    = ($urandom_range(0, 3) != 0);
            gc_bus.win      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Control FSM that sequences the memory-game datapath (FPGA shows a sequence, the user repeats it on SWITCH, and the datapath times and checks the entries).
- Drives the datapath command inputs (R1, R2, E1–E4, SEL) from the datapath status flags (end_FPGA, end_User, end_time, win, match) and the user's enter key.
- Sits beside the datapath in the top level and shares CLOCK_50 with it.

Parameters:
- STEP_CYCLES, 25000000: CLOCK_50 cycles between successive E2 step pulses while the FPGA plays its sequence (0.5 s).
- RESULT_HOLD, 50000000: minimum CLOCK_50 cycles spent in RESULT before enter is accepted.
- CNT_W, $clog2(RESULT_HOLD+1): width of the shared pacer/hold counter. It must also hold STEP_CYCLES-1.

Ports:
- CLOCK_50 in 1: system clock, all state on rising edge.
- reset in 1: asynchronous, active-high reset.
- enter_n in 1: enter key (KEY[0]), active-low, asynchronous to the clock.
- end_FPGA in 1: datapath has finished showing the sequence.
- end_User in 1: user has entered the full sequence.
- end_time in 1: user input timer expired.
- win in 1: final level completed.
- match in 1: user sequence equals FPGA sequence.
- R1 out 1: clear the game (setup, level and score registers).
- R2 out 1: clear the round (sequence index, timer, user counter).
- E1 out 1: load setup register from SWITCH.
- E2 out 1: advance the FPGA sequence step (one-cycle pulse).
- E3 out 1: capture one user entry (one-cycle pulse).
- E4 out 1: advance the level/round counter (one-cycle pulse).
- SEL out 1: display select, 0 = game display, 1 = result display.
- state out 3: current FSM state code, for debug LEDs.

Behaviour:
- Enter conditioning: enter_n passes through a 2-FF synchronizer. Then a falling-edge detector produces enter_p, a one-cycle pulse, 3 cycles after the press at most. A held key gives exactly one pulse.
- States and codes: INIT=0, SETUP=1, PREP=2, PLAY_FPGA=3, PLAY_USER=4, CHECK=5, NEXT=6, RESULT=7.
- Outputs are a Moore decode of the state register, except E2 and E3, which are registered pulses valid in their owning state only.
- INIT: R1=1, R2=1. Always goes to SETUP next cycle.
- SETUP: E1=1 every cycle. On enter_p, go to PREP.
- PREP: R2=1 for exactly one cycle, pacer cleared. Then go to PLAY_FPGA.
- PLAY_FPGA: SEL=0.
  - Pacer counts 0..STEP_CYCLES-1. E2 is high for one cycle when the pacer equals STEP_CYCLES-1, then the pacer wraps to 0.
  - If end_FPGA=1, go to PLAY_USER; no E2 is issued that cycle.
- PLAY_USER: SEL=0. E3 = enter_p, registered (one pulse per press).
  - end_time=1 takes priority: go to RESULT, with no E3 that cycle.
  - Else if end_User=1, go to CHECK.
- CHECK: one cycle, all enables 0. Exits on that cycle's flags:
  - match=1 and win=1: go to RESULT.
  - match=1 and win=0: go to NEXT.
  - match=0: go to RESULT.
- NEXT: E4=1 for one cycle, then go to PREP.
- RESULT: SEL=1.
  - Hold counter is cleared on entry and saturates at RESULT_HOLD.
  - enter_p is ignored until the counter reaches RESULT_HOLD. After that, enter_p goes to INIT.
- enter_p outside SETUP, PLAY_USER and eligible RESULT is discarded, never queued.
- Reset values (while reset=1 and immediately after): state=INIT, R1=1, R2=1, E1–E4=0, SEL=0, counters=0, synchronizer FFs=1 (key released).
- Reset mid-game returns to INIT asynchronously from any state. The datapath is therefore cleared by R1/R2 during reset.
- Status flags are sampled only in the states listed above. Flags in other states have no effect.
- E2, E3 and E4 are never high in the same cycle. R1/R2 are never high together with any E.

Test Plan:
(STEP_CYCLES=4, RESULT_HOLD=8)
1. Reset then release, hold enter_n=1 -> state 0 for one cycle (R1=R2=1), then state 1 with E1=1 held indefinitely.
2. In SETUP, drive enter_n low for 5 cycles -> exactly one PREP cycle (R2=1), then PLAY_FPGA with E2 pulses every 4th cycle. end_FPGA raised on a pulse cycle -> no E2 that cycle, state 4 next.
3. In PLAY_USER, press enter 3 times -> exactly 3 one-cycle E3 pulses. end_User=1, match=1, win=0 -> CHECK, then NEXT (E4 for 1 cycle), then PREP, then PLAY_FPGA.
4. In PLAY_USER, end_time=1 and end_User=1 in the same cycle -> state 7, SEL=1, no E3.
5. In CHECK, match=0 -> RESULT. Enter pressed at 3 cycles in is ignored; enter after 8 cycles -> INIT, then SETUP.
6. Assert reset mid PLAY_FPGA between pulses -> outputs immediately R1=R2=1, E2=0, state=0. After release, the pacer restarts from 0.
